seg_scan_decoder: RTL and testbench

Readback decoder for the multiplexed seven-segment display path. It samples the segment and digit-enable lines that drive the display, waits for each digit's pattern to settle, and decodes each pattern back into a 4-bit hex nibble. Once every digit has been captured, it publishes the whole multi-digit value. It sits beside the display driver of the frequency meter so the displayed reading can be checked against the internally computed count.

---
 rtl/seg_scan_decoder.sv | 136 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: reads back the multiplexed 7-segment lines,
// captures each settled digit and publishes whole decoded frames.
module seg_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          segments,
  input  logic [DIGITS-1:0]   digit_en,
  output logic [4*DIGITS-1:0] value,
  output logic                frame_valid,
  output logic                frame_err
);

  localparam int SW = DIGITS + 7;
  localparam logic [7:0] CMAX = 8'(STABLE - 1);

  typedef enum logic {SETTLE, HELD} state_t;

  state_t state, state_nx;

  logic [SW-1:0]       raw;
  logic [SW-1:0]       smp;
  logic [7:0]          cnt;
  logic                diff;
  logic                one_hot;
  logic                capture;
  logic                illegal;
  logic                complete;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   en;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   bad;
  logic [DIGITS-1:0]   seen_base;
  logic [DIGITS-1:0]   bad_base;
  logic [4*DIGITS-1:0] shadow;

  assign raw      = {digit_en, segments};
  assign diff     = raw != smp;
  assign en       = smp[SW-1:7];
  assign one_hot  = $onehot(en);
  assign complete = &seen;

  // cnt tracks how long smp has held its current value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '0;
      cnt <= '0;
    end else begin
      smp <= raw;
      if (diff)
        cnt <= '0;
      else if (cnt < CMAX)
        cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= SETTLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (diff)
      state_nx = SETTLE;
    else if (capture)
      state_nx = HELD;
  end

  always_comb begin
    capture = (state == SETTLE) && (cnt == CMAX) && one_hot;
  end

  always_comb begin
    nib     = '0;
    illegal = 1'b0;
    unique case (smp[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h7B: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: illegal = 1'b1;
    endcase
  end

  // a capture in the completion cycle starts the next frame
  always_comb begin
    seen_base = complete ? '0 : seen;
    bad_base  = complete ? '0 : bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      seen        <= '0;
      bad         <= '0;
      shadow      <= '0;
    end else begin
      frame_valid <= complete;
      if (complete) begin
        value     <= shadow;
        frame_err <= |bad;
      end
      if (capture) begin
        seen <= seen_base | en;
        bad  <= (bad_base & ~en) | (illegal ? en : '0);
      end else begin
        seen <= seen_base;
        bad  <= bad_base;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (capture && en[i])
          shadow[4*i +: 4] <= nib;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized scenarios against a
// behavioural readback model of the display path.
module tb_seg_scan_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  typedef struct {
    logic [15:0] v;
    logic        er;
    int          c;
  } fr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  segments = '0;
  logic [3:0]  digit_en = '0;
  logic [15:0] value;
  logic        frame_valid;
  logic        frame_err;

  int tests = 0;
  int fails = 0;
  int e = 0;

  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .segments(segments),
    .digit_en(digit_en),
    .value(value),
    .frame_valid(frame_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h7B, 7'h71
  };

  // observed frames
  fr_t  dq[$];
  int   wide = 0;
  int   min_gap = 1000000;
  logic prev_fv = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_fv = 1'b0;
    end else begin
      if (frame_valid) begin
        if (prev_fv) wide++;
        if (dq.size() > 0 && e - dq[$].c < min_gap)
          min_gap = e - dq[$].c;
        dq.push_back('{value, frame_err, e});
      end
      prev_fv = frame_valid;
    end
  end

  // reference model
  fr_t         mq[$];
  logic [10:0] m_cur;
  int          m_run;
  logic [3:0]  m_seen;
  logic [3:0]  m_bad;
  logic [15:0] m_shadow;

  function automatic void lookup(input logic [6:0] s,
                                 output logic [3:0] n,
                                 output logic ill);
    n = '0;
    ill = 1'b1;
    for (int j = 0; j < 16; j++)
      if (tbl[j] == s) begin
        n = 4'(j);
        ill = 1'b0;
      end
  endfunction

  task automatic m_reset();
    m_cur = '0;
    m_run = 0;
    m_seen = '0;
    m_bad = '0;
    m_shadow = '0;
  endtask

  task automatic model_step(input logic [6:0] s, input logic [3:0] en);
    logic [3:0] n;
    logic       ill;
    int         idx;
    if (m_seen == 4'hF) begin
      mq.push_back('{m_shadow, |m_bad, e});
      m_seen = '0;
      m_bad = '0;
    end
    if (m_run == STABLE && $countones(m_cur[10:7]) == 1) begin
      lookup(m_cur[6:0], n, ill);
      idx = 0;
      for (int j = 0; j < 4; j++)
        if (m_cur[7+j]) idx = j;
      m_shadow[idx*4 +: 4] = n;
      m_seen[idx] = 1'b1;
      m_bad[idx] = ill;
    end
    if ({en, s} == m_cur) begin
      m_run++;
    end else begin
      m_cur = {en, s};
      m_run = 1;
    end
  endtask

  task automatic tick(input logic [6:0] s, input logic [3:0] en);
    segments = s;
    digit_en = en;
    @(posedge clk);
    e++;
    model_step(s, en);
    #1;
  endtask

  task automatic digit(input int i, input logic [6:0] s,
                       input int hold, input int gap);
    repeat (hold) tick(s, 4'(1 << i));
    repeat (gap) tick(7'h00, 4'h0);
  endtask

  function automatic fr_t last_d();
    fr_t z = '{16'h0, 1'b0, -1};
    return dq.size() > 0 ? dq[$] : z;
  endfunction

  function automatic fr_t last_m();
    fr_t z = '{16'h0, 1'b0, -2};
    return mq.size() > 0 ? mq[$] : z;
  endfunction

  function automatic logic [6:0] rnd_bad();
    logic [6:0] s;
    logic [3:0] n;
    logic       ill;
    do begin
      s = 7'($urandom_range(127));
      lookup(s, n, ill);
    end while (!ill);
    return s;
  endfunction

  task automatic test_reset();
    tests++;
    if (value !== 16'h0) begin
      fails++;
      $display("FAIL reset_value got %h exp 0000", value);
    end
    tests++;
    if (frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_fv got %b exp 0", frame_valid);
    end
    tests++;
    if (frame_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_err got %b exp 0", frame_err);
    end
  endtask

  task automatic test_basic();
    int  f0 = dq.size();
    fr_t d, m;
    digit(0, 7'h4F, 8, 2);
    digit(1, 7'h66, 8, 2);
    digit(2, 7'h5B, 8, 2);
    digit(3, 7'h06, 8, 2);
    repeat (4) tick(7'h00, 4'h0);
    d = last_d();
    m = last_m();
    tests++;
    if (dq.size() - f0 != 1) begin
      fails++;
      $display("FAIL basic_count got %0d exp 1", dq.size() - f0);
    end
    tests++;
    if (d.v !== 16'h1243) begin
      fails++;
      $display("FAIL basic_value got %h exp 1243", d.v);
    end
    tests++;
    if (d.er !== 1'b0) begin
      fails++;
      $display("FAIL basic_err got %b exp 0", d.er);
    end
    tests++;
    if (d.c != m.c) begin
      fails++;
      $display("FAIL basic_latency got %0d exp %0d", d.c, m.c);
    end
  endtask

  task automatic test_glitch();
    fr_t d, m;
    for (int k = 0; k < 2; k++) begin
      digit(0, 7'h3F, 6, 2);
      digit(1, 7'h06, 6, 2);
      digit(1, 7'h7F, 3 + k, 2);
      digit(2, 7'h5B, 6, 1);
      digit(3, 7'h4F, 6, 3);
      repeat (4) tick(7'h00, 4'h0);
      d = last_d();
      m = last_m();
      tests++;
      if (d.v[7:4] !== (k == 0 ? 4'h1 : 4'h8)) begin
        fails++;
        $display("FAIL glitch_nib%0d got %h", 3 + k, d.v[7:4]);
      end
      tests++;
      if (d.v !== m.v || d.c != m.c) begin
        fails++;
        $display("FAIL glitch_model%0d got %h@%0d exp %h@%0d",
                 3 + k, d.v, d.c, m.v, m.c);
      end
    end
  endtask

  task automatic test_illegal();
    fr_t d;
    logic [6:0] s [4] = '{7'h7D, 7'h7D, 7'h00, 7'h7D};
    for (int i = 0; i < 4; i++)
      digit(i, s[i], STABLE + $urandom_range(4), $urandom_range(2));
    repeat (4) tick(7'h00, 4'h0);
    d = last_d();
    tests++;
    if (d.v !== 16'h6066 || d.er !== 1'b1) begin
      fails++;
      $display("FAIL illegal_frame got %h/%b exp 6066/1", d.v, d.er);
    end
    for (int i = 0; i < 4; i++)
      digit(i, tbl[$urandom_range(15)], STABLE + $urandom_range(4), 1);
    repeat (4) tick(7'h00, 4'h0);
    d = last_d();
    tests++;
    if (d.er !== 1'b0 || d.v !== last_m().v) begin
      fails++;
      $display("FAIL illegal_recover got %h/%b exp %h/0",
               d.v, d.er, last_m().v);
    end
  endtask

  task automatic test_decode_table();
    int  f0 = dq.size();
    fr_t d;
    for (int k = 0; k < 16; k++) begin
      digit(0, tbl[k], STABLE + $urandom_range(5), $urandom_range(3));
      for (int i = 1; i < 4; i++)
        digit(i, tbl[$urandom_range(15)],
              STABLE + $urandom_range(5), $urandom_range(3));
      repeat (4) tick(7'h00, 4'h0);
      d = last_d();
      tests++;
      if (d.v[3:0] !== 4'(k) || d.er !== 1'b0 ||
          dq.size() - f0 != k + 1) begin
        fails++;
        $display("FAIL decode_%0d got %h/%b n=%0d", k, d.v[3:0], d.er,
                 dq.size() - f0);
      end
      tests++;
      if (d.v !== last_m().v) begin
        fails++;
        $display("FAIL decode_model_%0d got %h exp %h", k, d.v,
                 last_m().v);
      end
    end
  endtask

  task automatic test_enable_errors();
    int  f0 = dq.size();
    fr_t d;
    repeat (20) tick(7'h06, 4'b0011);
    digit(2, 7'h5B, 5, 1);
    digit(3, 7'h4F, 5, 1);
    repeat (4) tick(7'h00, 4'h0);
    tests++;
    if (dq.size() != f0) begin
      fails++;
      $display("FAIL multihot_count got %0d exp 0", dq.size() - f0);
    end
    digit(1, 7'h66, 5, 1);
    digit(0, 7'h7F, 100, 0);
    repeat (4) tick(7'h00, 4'h0);
    d = last_d();
    tests++;
    if (dq.size() != f0 + 1 || d.v !== 16'h3248) begin
      fails++;
      $display("FAIL longhold_frame got %h n=%0d exp 3248 n=1",
               d.v, dq.size() - f0);
    end
    digit(1, 7'h06, 5, 1);
    digit(2, 7'h06, 5, 1);
    digit(3, 7'h06, 5, 1);
    repeat (4) tick(7'h00, 4'h0);
    tests++;
    if (dq.size() != f0 + 1) begin
      fails++;
      $display("FAIL longhold_once got %0d exp 1", dq.size() - f0);
    end
    digit(0, 7'h3F, 5, 1);
    repeat (4) tick(7'h00, 4'h0);
    d = last_d();
    tests++;
    if (dq.size() != f0 + 2 || d.v !== 16'h1110) begin
      fails++;
      $display("FAIL longhold_next got %h n=%0d exp 1110 n=2",
               d.v, dq.size() - f0);
    end
  endtask

  task automatic test_back_to_back();
    int d0 = dq.size();
    int m0 = mq.size();
    int last = -1;
    int ord [4];
    int t;
    logic [6:0] s;
    for (int f = 0; f < 10; f++) begin
      ord = '{0, 1, 2, 3};
      for (int j = 3; j > 0; j--) begin
        int r = $urandom_range(j);
        t = ord[j];
        ord[j] = ord[r];
        ord[r] = t;
      end
      if (ord[0] == last) begin
        t = ord[0];
        ord[0] = ord[1];
        ord[1] = t;
      end
      for (int j = 0; j < 4; j++) begin
        s = ($urandom_range(4) == 0) ? rnd_bad() : tbl[$urandom_range(15)];
        digit(ord[j], s, STABLE, 0);
      end
      last = ord[3];
    end
    repeat (6) tick(7'h00, 4'h0);
    tests++;
    if (dq.size() - d0 != 10) begin
      fails++;
      $display("FAIL b2b_count got %0d exp 10", dq.size() - d0);
    end
    for (int i = 0; i < 10; i++) begin
      if (d0 + i < dq.size() && m0 + i < mq.size()) begin
        tests++;
        if (dq[d0+i].v !== mq[m0+i].v || dq[d0+i].er !== mq[m0+i].er ||
            dq[d0+i].c != mq[m0+i].c) begin
          fails++;
          $display("FAIL b2b_frame%0d got %h/%b@%0d exp %h/%b@%0d", i,
                   dq[d0+i].v, dq[d0+i].er, dq[d0+i].c,
                   mq[m0+i].v, mq[m0+i].er, mq[m0+i].c);
        end
      end
    end
    tests++;
    if (wide != 0) begin
      fails++;
      $display("FAIL pulse_width got %0d wide pulses exp 0", wide);
    end
    tests++;
    if (min_gap < DIGITS * STABLE) begin
      fails++;
      $display("FAIL pulse_gap got %0d exp >= %0d", min_gap,
               DIGITS * STABLE);
    end
  endtask

  task automatic test_reset_mid();
    int  f0;
    fr_t d;
    digit(0, rnd_bad(), 5, 1);
    digit(1, 7'h7D, 5, 1);
    digit(2, 7'h6D, 5, 1);
    digit(3, 7'h66, 5, 1);
    repeat (4) tick(7'h00, 4'h0);
    tests++;
    if (frame_err !== 1'b1 || value !== 16'h4560) begin
      fails++;
      $display("FAIL premid_frame got %h/%b exp 4560/1", value, frame_err);
    end
    digit(0, 7'h3F, 5, 1);
    digit(1, 7'h06, 5, 1);
    digit(2, 7'h5B, 5, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (value !== 16'h0 || frame_valid !== 1'b0 || frame_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got %h/%b/%b exp 0000/0/0",
               value, frame_valid, frame_err);
    end
    m_reset();
    segments = '0;
    digit_en = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    f0 = dq.size();
    digit(3, 7'h4F, 6, 1);
    repeat (4) tick(7'h00, 4'h0);
    tests++;
    if (dq.size() != f0) begin
      fails++;
      $display("FAIL reset_discard got %0d frames exp 0", dq.size() - f0);
    end
    digit(0, 7'h3F, 5, 1);
    digit(1, 7'h06, 5, 1);
    digit(2, 7'h5B, 5, 1);
    repeat (4) tick(7'h00, 4'h0);
    d = last_d();
    tests++;
    if (dq.size() != f0 + 1 || d.v !== 16'h3210 || d.er !== 1'b0) begin
      fails++;
      $display("FAIL reset_refill got %h/%b n=%0d exp 3210/0 n=1",
               d.v, d.er, dq.size() - f0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_glitch();
    test_illegal();
    test_decode_table();
    test_enable_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
